// File: rtl/jelly_rand_check.sv
// jelly_rand_check
// Receive-side checker for the 16-bit LFSR stream b[n] = b[n-16]^b[n-14]^b[n-13]^b[n-11].
// Self-synchronises (HUNT -> SYNC -> LOCKED), then flywheels on its own
// prediction and counts checked bits and bit errors.
//
// Handshake: there is no ready; cke is a pure bit-valid strobe. in_data is
// consumed on every rising clk edge where cke=1 and ignored otherwise.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   cke        bit-valid strobe
//   clear      synchronous clear of bit_count/err_count (state untouched)
//   in_data    received serial bit
//   locked     1 while in LOCKED
//   err        one-cycle pulse per mismatched bit while LOCKED
//   bit_count  bits checked while LOCKED (saturating)
//   err_count  errors seen while LOCKED (saturating)
//   dbg_state  current FSM state (HUNT=0, SYNC=1, LOCKED=2)
module jelly_rand_check #(
  parameter int LOCK_COUNT    = 32,
  parameter int WINDOW_LEN    = 256,
  parameter int UNLOCK_ERRORS = 16,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cke,
  input  logic                   clear,
  input  logic                   in_data,
  output logic                   locked,
  output logic                   err,
  output logic [COUNT_WIDTH-1:0] bit_count,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic [1:0]             dbg_state
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [15:0] LOCK_L   = 16'(LOCK_COUNT);
  localparam logic [15:0] WIN_L    = 16'(WINDOW_LEN);
  localparam logic [15:0] UNLOCK_L = 16'(UNLOCK_ERRORS);

  logic [1:0]             state_q, state_d;
  logic [15:0]            h_q, h_d;
  logic [4:0]             fill_q, fill_d;
  logic [15:0]            match_q, match_d;
  logic [15:0]            win_q, win_d;
  logic [15:0]            werr_q, werr_d;
  logic                   err_q, err_d;
  logic [COUNT_WIDTH-1:0] bit_q, bit_d;
  logic [COUNT_WIDTH-1:0] ec_q, ec_d;

  logic        pred;
  logic        mism;
  logic [15:0] match_inc;
  logic [15:0] win_inc;
  logic [15:0] werr_inc;

  // h[k] is the bit received k+1 samples ago, so the taps sit at k = n-1.
  assign pred      = h_q[15] ^ h_q[13] ^ h_q[12] ^ h_q[10];
  assign mism      = in_data ^ pred;
  assign match_inc = match_q + 16'd1;
  assign win_inc   = win_q + 16'd1;
  assign werr_inc  = werr_q + {15'd0, mism};

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = 1'b0;
    bit_d   = bit_q;
    ec_d    = ec_q;

    if (cke) begin
      case (state_q)
        HUNT: begin
          h_d    = {h_q[14:0], in_data};
          fill_d = fill_q + 5'd1;
          if (fill_q == 5'd15) begin
            state_d = SYNC;
            match_d = 16'd0;
          end
        end
        SYNC: begin
          h_d = {h_q[14:0], in_data};
          // An all-zero history predicts 0 forever; never let it count.
          if (!mism && (h_q != 16'd0)) begin
            match_d = match_inc;
            if (match_inc == LOCK_L) begin
              state_d = LOCKED;
              win_d   = 16'd0;
              werr_d  = 16'd0;
            end
          end else begin
            match_d = 16'd0;
          end
        end
        LOCKED: begin
          // Flywheel: feed back the prediction so a line error is not re-used.
          h_d = {h_q[14:0], pred};
          if (bit_q != '1) bit_d = bit_q + 1'b1;
          if (mism) begin
            err_d = 1'b1;
            if (ec_q != '1) ec_d = ec_q + 1'b1;
          end
          if (werr_inc == UNLOCK_L) begin
            state_d = HUNT;
            h_d     = 16'd0;
            fill_d  = 5'd0;
            match_d = 16'd0;
            win_d   = 16'd0;
            werr_d  = 16'd0;
          end else if (win_inc == WIN_L) begin
            win_d  = 16'd0;
            werr_d = 16'd0;
          end else begin
            win_d  = win_inc;
            werr_d = werr_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // clear acts regardless of cke and beats any increment on this edge.
    if (clear) begin
      bit_d = '0;
      ec_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      h_q     <= 16'd0;
      fill_q  <= 5'd0;
      match_q <= 16'd0;
      win_q   <= 16'd0;
      werr_q  <= 16'd0;
      err_q   <= 1'b0;
      bit_q   <= '0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
      bit_q   <= bit_d;
      ec_q    <= ec_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign bit_count = bit_q;
  assign err_count = ec_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_jelly_rand_check.sv
module tb_jelly_rand_check;

  // ---------------- clock / reset / DUTs ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cke = 1'b0;
  logic        clear = 1'b0;
  logic        in_data = 1'b0;
  logic        locked, err;
  logic [31:0] bit_count, err_count;
  logic [1:0]  dbg_state;
  logic        locked4, err4;
  logic [3:0]  bit_count4, err_count4;
  logic [1:0]  dbg_state4;

  always #5 clk = ~clk;

  jelly_rand_check dut (
    .clk(clk), .reset(reset), .cke(cke), .clear(clear), .in_data(in_data),
    .locked(locked), .err(err), .bit_count(bit_count), .err_count(err_count),
    .dbg_state(dbg_state)
  );

  jelly_rand_check #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .cke(cke), .clear(clear), .in_data(in_data),
    .locked(locked4), .err(err4), .bit_count(bit_count4), .err_count(err_count4),
    .dbg_state(dbg_state4)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference stream ----------------
  // Generated straight from the recurrence, seeded with 0xACE1.
  logic stream_bits [0:4095];
  int   pos = 0;

  task automatic build_stream();
    logic [15:0] seed;
    seed = 16'hACE1;
    for (int i = 0; i < 16; i++) stream_bits[i] = seed[15-i];
    for (int i = 16; i < 4096; i++)
      stream_bits[i] = stream_bits[i-16] ^ stream_bits[i-14] ^ stream_bits[i-13] ^ stream_bits[i-11];
  endtask

  task automatic get_bit(output logic b);
    b = stream_bits[pos];
    pos = pos + 1;
  endtask

  // ---------------- driver tasks ----------------
  // Inputs applied, one rising edge, then outputs sampled 1ns later.
  task automatic cycle(input logic d, input logic ck, input logic clr);
    in_data = d;
    cke     = ck;
    clear   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    pos = 0;
  endtask

  // Feeds 48 clean bits; lock must appear exactly on the 48th.
  task automatic send_to_lock(input string tag);
    logic b;
    for (int i = 1; i <= 48; i++) begin
      get_bit(b);
      cycle(b, 1'b1, 1'b0);
      checks++;
      if (locked !== (i == 48)) begin
        failures++;
        $display("FAIL %s_lock bit=%0d: got locked=%b expected %b", tag, i, locked, (i == 48));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks += 5;
    if (locked !== 1'b0)     begin failures++; $display("FAIL reset_locked: got %b expected 0", locked); end
    if (err !== 1'b0)        begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
    if (bit_count !== 32'd0) begin failures++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
    if (err_count !== 32'd0) begin failures++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    if (err_count4 !== 4'd0) begin failures++; $display("FAIL reset_err_count4: got %0d expected 0", err_count4); end
  endtask

  task automatic test_lock();
    logic b;
    send_to_lock("clean");
    for (int i = 0; i < 100; i++) begin
      get_bit(b);
      cycle(b, 1'b1, 1'b0);
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL clean_err bit=%0d: got %b expected 0", i, err); end
    end
    checks += 2;
    if (bit_count !== 32'd100) begin failures++; $display("FAIL clean_bit_count: got %0d expected 100", bit_count); end
    if (err_count !== 32'd0)   begin failures++; $display("FAIL clean_err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_single_error();
    logic b;
    for (int i = 0; i < 20; i++) begin get_bit(b); cycle(b, 1'b1, 1'b0); end
    get_bit(b);
    cycle(~b, 1'b1, 1'b0);
    checks += 3;
    if (err !== 1'b1)        begin failures++; $display("FAIL single_err_pulse: got %b expected 1", err); end
    if (err_count !== 32'd1) begin failures++; $display("FAIL single_err_count: got %0d expected 1", err_count); end
    if (locked !== 1'b1)     begin failures++; $display("FAIL single_locked: got %b expected 1", locked); end
    for (int i = 0; i < 30; i++) begin
      get_bit(b);
      cycle(b, 1'b1, 1'b0);
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL single_after_err bit=%0d: got %b expected 0", i, err); end
    end
    checks += 2;
    if (bit_count !== 32'd151) begin failures++; $display("FAIL single_bit_count: got %0d expected 151", bit_count); end
    if (err_count !== 32'd1)   begin failures++; $display("FAIL single_err_count_end: got %0d expected 1", err_count); end
  endtask

  task automatic test_unlock();
    logic b;
    do_reset();
    send_to_lock("unlock_pre");
    for (int i = 0; i < 5; i++) begin get_bit(b); cycle(b, 1'b1, 1'b0); end
    for (int i = 1; i <= 16; i++) begin
      get_bit(b);
      cycle(~b, 1'b1, 1'b0);
      checks += 2;
      if (err !== 1'b1) begin failures++; $display("FAIL unlock_err_pulse n=%0d: got %b expected 1", i, err); end
      if (locked !== (i < 16)) begin
        failures++; $display("FAIL unlock_locked n=%0d: got %b expected %b", i, locked, (i < 16));
      end
    end
    checks += 2;
    if (err_count !== 32'd16) begin failures++; $display("FAIL unlock_err_count: got %0d expected 16", err_count); end
    if (bit_count !== 32'd21) begin failures++; $display("FAIL unlock_bit_count: got %0d expected 21", bit_count); end
    send_to_lock("relock");
    for (int i = 0; i < 10; i++) begin get_bit(b); cycle(b, 1'b1, 1'b0); end
    checks += 2;
    if (bit_count !== 32'd31) begin failures++; $display("FAIL relock_bit_count: got %0d expected 31", bit_count); end
    if (err_count !== 32'd16) begin failures++; $display("FAIL relock_err_count: got %0d expected 16", err_count); end
  endtask

  // Random sparse line errors (kept below the unlock threshold per window).
  task automatic test_random_errors();
    logic       b, flip;
    logic [0:0] exp_q [$];
    logic [0:0] e;
    int         per_win [0:3];
    int         exp_bits, exp_errs;
    do_reset();
    send_to_lock("random_pre");
    for (int w = 0; w < 4; w++) per_win[w] = 0;
    exp_bits = 0;
    exp_errs = 0;
    for (int j = 0; j < 600; j++) begin
      get_bit(b);
      flip = ($urandom_range(0, 31) == 0) && (per_win[j / 256] < 12);
      if (flip) begin per_win[j / 256]++; exp_errs++; end
      exp_bits++;
      exp_q.push_back(flip);
      cycle(b ^ flip, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks += 2;
      if (err !== e[0])    begin failures++; $display("FAIL random_err bit=%0d: got %b expected %b", j, err, e[0]); end
      if (locked !== 1'b1) begin failures++; $display("FAIL random_locked bit=%0d: got %b expected 1", j, locked); end
    end
    checks += 2;
    if (bit_count !== 32'(exp_bits)) begin failures++; $display("FAIL random_bit_count: got %0d expected %0d", bit_count, exp_bits); end
    if (err_count !== 32'(exp_errs)) begin failures++; $display("FAIL random_err_count: got %0d expected %0d", err_count, exp_errs); end
  endtask

  task automatic test_stuck_zero();
    int lock_seen;
    do_reset();
    lock_seen = 0;
    for (int i = 0; i < 10000; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (locked !== 1'b0) lock_seen++;
    end
    checks += 3;
    if (lock_seen != 0)      begin failures++; $display("FAIL stuck0_locked: got %0d locked cycles expected 0", lock_seen); end
    if (bit_count !== 32'd0) begin failures++; $display("FAIL stuck0_bit_count: got %0d expected 0", bit_count); end
    if (err_count !== 32'd0) begin failures++; $display("FAIL stuck0_err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_cke_gaps();
    logic        b, ck;
    int          sampled;
    int          cyc;
    logic [31:0] held;
    do_reset();
    sampled = 0;
    cyc = 0;
    while (sampled < 60 && cyc < 400) begin
      ck = ($urandom_range(0, 2) != 0);
      b = 1'b0;
      if (ck) begin get_bit(b); sampled++; end
      else b = 1'($urandom_range(0, 1));
      cycle(b, ck, 1'b0);
      cyc++;
      checks++;
      if (locked !== (sampled >= 48)) begin
        failures++; $display("FAIL gaps_locked sampled=%0d: got %b expected %b", sampled, locked, (sampled >= 48));
      end
    end
    checks++;
    if (sampled < 60) begin failures++; $display("FAIL gaps_budget: got %0d samples expected 60", sampled); end
    held = bit_count;
    get_bit(b);
    cycle(~b, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL gaps_err_pulse: got %b expected 1", err); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checks += 3;
      if (err !== 1'b0)             begin failures++; $display("FAIL frozen_err i=%0d: got %b expected 0", i, err); end
      if (bit_count !== held + 32'd1) begin failures++; $display("FAIL frozen_bit_count i=%0d: got %0d expected %0d", i, bit_count, held + 1); end
      if (locked !== 1'b1)          begin failures++; $display("FAIL frozen_locked i=%0d: got %b expected 1", i, locked); end
    end
  endtask

  task automatic test_clear();
    logic b;
    do_reset();
    send_to_lock("clear_pre");
    for (int i = 0; i < 10; i++) begin get_bit(b); cycle(b, 1'b1, 1'b0); end
    get_bit(b);
    cycle(~b, 1'b1, 1'b1);
    checks += 4;
    if (err !== 1'b1)        begin failures++; $display("FAIL clear_err_pulse: got %b expected 1", err); end
    if (err_count !== 32'd0) begin failures++; $display("FAIL clear_err_count: got %0d expected 0", err_count); end
    if (bit_count !== 32'd0) begin failures++; $display("FAIL clear_bit_count: got %0d expected 0", bit_count); end
    if (locked !== 1'b1)     begin failures++; $display("FAIL clear_locked: got %b expected 1", locked); end
    get_bit(b);
    cycle(b, 1'b1, 1'b0);
    checks += 2;
    if (bit_count !== 32'd1) begin failures++; $display("FAIL clear_after_bits: got %0d expected 1", bit_count); end
    if (err !== 1'b0)        begin failures++; $display("FAIL clear_after_err: got %b expected 0", err); end
  endtask

  // 20 errors spaced 50 bits apart: never more than 6 in one window.
  task automatic test_saturation();
    logic b, flip;
    do_reset();
    send_to_lock("sat_pre");
    for (int j = 0; j < 1000; j++) begin
      get_bit(b);
      flip = (j % 50 == 10);
      cycle(b ^ flip, 1'b1, 1'b0);
    end
    checks += 5;
    if (err_count !== 32'd20)   begin failures++; $display("FAIL sat_err_count32: got %0d expected 20", err_count); end
    if (bit_count !== 32'd1000) begin failures++; $display("FAIL sat_bit_count32: got %0d expected 1000", bit_count); end
    if (err_count4 !== 4'd15)   begin failures++; $display("FAIL sat_err_count4: got %0d expected 15", err_count4); end
    if (bit_count4 !== 4'd15)   begin failures++; $display("FAIL sat_bit_count4: got %0d expected 15", bit_count4); end
    if (locked4 !== 1'b1)       begin failures++; $display("FAIL sat_locked4: got %b expected 1", locked4); end
  endtask

  task automatic test_reset_mid();
    logic b;
    do_reset();
    send_to_lock("mid_pre");
    for (int j = 0; j < 30; j++) begin
      get_bit(b);
      cycle(b ^ (j % 5 == 3 && j < 25), 1'b1, 1'b0);
    end
    checks++;
    if (err_count !== 32'd5) begin failures++; $display("FAIL mid_err_count_pre: got %0d expected 5", err_count); end
    get_bit(b);
    reset = 1'b1;
    cycle(~b, 1'b1, 1'b0);
    reset = 1'b0;
    checks += 4;
    if (locked !== 1'b0)     begin failures++; $display("FAIL mid_locked: got %b expected 0", locked); end
    if (err !== 1'b0)        begin failures++; $display("FAIL mid_err: got %b expected 0", err); end
    if (bit_count !== 32'd0) begin failures++; $display("FAIL mid_bit_count: got %0d expected 0", bit_count); end
    if (err_count !== 32'd0) begin failures++; $display("FAIL mid_err_count: got %0d expected 0", err_count); end
    send_to_lock("mid_relock");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    build_stream();
    test_reset();
    test_lock();
    test_single_error();
    test_unlock();
    test_random_errors();
    test_stuck_zero();
    test_cke_gaps();
    test_clear();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jelly_rand_check.md
Name: jelly_rand_check

Overview:
- Receive-side checker for the 16-bit LFSR pseudo-random bit stream produced by the team's random generator. Recurrence: b[n] = b[n-16] ^ b[n-14] ^ b[n-13] ^ b[n-11].
- Self-synchronises to the incoming serial stream, with no seed needed. Declares lock, then counts checked bits and bit errors.
- Used as link/BER monitor on loopback paths and in generator self-test benches.

Parameters:
- LOCK_COUNT, 32: consecutive correct predictions required in SYNC to declare lock (1..65535).
- WINDOW_LEN, 256: bits per loss-of-lock evaluation window (2..65535).
- UNLOCK_ERRORS, 16: errors within one window that force return to HUNT (1..WINDOW_LEN).
- COUNT_WIDTH, 32: width of bit_count and err_count.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- cke  input  1  bit-valid strobe; in_data sampled only when cke=1
- clear  input  1  synchronous clear of bit_count/err_count; state untouched
- in_data  input  1  received serial bit
- locked  output  1  1 while in LOCKED state
- err  output  1  one-cycle pulse per mismatched bit while LOCKED
- bit_count  output  COUNT_WIDTH  bits checked in LOCKED, saturating
- err_count  output  COUNT_WIDTH  errors seen in LOCKED, saturating

Behaviour:
- Internal 16-bit history h, with h[k] = bit received k+1 samples ago. Prediction p = h[15]^h[13]^h[12]^h[10].
- Reset:
  - state=HUNT, h=0, all internal counters 0.
  - locked=0, err=0, bit_count=0, err_count=0.
- All state, history and counter updates occur only on clock edges with cke=1, except these, which act regardless of cke:
  - err clears to 0 on any edge without a new error.
  - clear.
- HUNT:
  - h <= {h[14:0], in_data}; fill counter increments.
  - After the 16th sampled bit -> SYNC; match counter = 0.
- SYNC:
  - h shifts in in_data (open loop).
  - in_data==p and h!=0: match counter +1.
  - Otherwise: match counter = 0. The all-zero history never counts, so a stuck-at-0 stream never locks.
  - On the LOCK_COUNT-th consecutive match -> LOCKED. locked=1 visible after that edge. Window counter and window error counter = 0.
- LOCKED (flywheel):
  - h <= {h[14:0], p}, i.e. the prediction, not the received bit. A single line error therefore produces exactly one err pulse, with no error multiplication.
  - Mismatch (in_data!=p): err=1 for the following cycle; err_count +1; window error counter +1.
  - Every sampled bit: bit_count +1; window counter +1.
  - Window error counter reaches UNLOCK_ERRORS -> HUNT. Takes priority over window rollover on the same edge. locked=0 after that edge. The error that triggers it is still counted and pulsed. h and fill counter clear.
  - Otherwise, when window counter reaches WINDOW_LEN: both window counters reset to 0.
- Counters:
  - bit_count and err_count saturate at all-ones, never wrap.
  - Held (not cleared) on loss of lock.
  - Counting occurs only in LOCKED.
- clear:
  - bit_count=0, err_count=0 on that edge.
  - Wins over a simultaneous increment; err pulse is still generated.
  - Does not affect state, h, window counters or locked.
- reset asserted mid-operation, in any state: full reset values on that edge; no err pulse afterwards.
- cke=0: all state frozen; err deasserts after one cycle.

Test Plan:
- Generator seed 0xACE1, cke=1 continuous, default params -> locked rises after the edge sampling bit 48 (16 fill + 32 matches). err never pulses; bit_count = N-48 after N bits; err_count=0.
- Locked stream, invert exactly one bit -> exactly one err pulse, one cycle after sampling; err_count=1; locked stays 1; subsequent bits all match.
- Locked stream, invert 16 bits within 256 -> locked falls after the 16th error edge. err_count=16. Relocks 48 bits later and counting resumes from 16.
- Constant in_data=0 for 10000 bits -> locked stays 0; bit_count=err_count=0. Same with random cke gaps on a valid stream -> lock still at the 48th sampled bit.
- clear asserted on the same edge as an error while locked -> err_count=0 and err pulse present. COUNT_WIDTH=4 with 20 errors spread across windows -> err_count holds 15.
- reset asserted while LOCKED with 5 errors counted -> next cycle locked=0 and counts 0. Relock takes 48 bits.
